// File: rtl/fifo_read_packer.sv
// fifo_read_packer: read-side consumer of an async FIFO. Issues FIFO reads,
// captures each word one cycle after its read fires, packs PACK_RATIO words
// into one wide beat and presents it on a valid/ready stream. A flush pulse
// forces out a partially filled beat once every in-flight word has landed.
module fifo_read_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int PACK_RATIO = 4,
  parameter int CNT_WIDTH  = $clog2(PACK_RATIO + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]            fifo_data_i,
  output logic                             fifo_read_en_o,
  input  logic                             flush_i,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data_o,
  output logic [CNT_WIDTH-1:0]             m_count_o,
  output logic                             busy_o
);

  // One extra bit so fill level plus an in-flight word can never wrap.
  localparam int SUM_W = CNT_WIDTH + 1;
  localparam int IDX_W = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
  localparam logic [SUM_W-1:0] FULL = SUM_W'(PACK_RATIO);

  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc;
  logic [SUM_W-1:0]                      acc_cnt;
  logic                                  pending;
  logic                                  flush_pend;

  logic             fire;
  logic             full;
  logic             out_free;
  logic             flush_go;
  logic             xfer;
  logic [SUM_W-1:0] fill_sum;
  logic [IDX_W-1:0] lane_idx;

  // Zero every lane at or above cnt so a partial beat never leaks stale words.
  function automatic logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] mask_lanes(
    input logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes,
    input logic [SUM_W-1:0]                      cnt
  );
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] r;
    for (int k = 0; k < PACK_RATIO; k++) begin
      r[k] = (SUM_W'(k) < cnt) ? lanes[k] : '0;
    end
    return r;
  endfunction

  assign fire     = fifo_read_en_o & ~fifo_empty_i;
  assign full     = (acc_cnt == FULL);
  assign out_free = ~m_valid_o | m_ready_i;
  assign flush_go = flush_pend & ~pending & (acc_cnt != '0);
  assign xfer     = (full | flush_go) & out_free;
  assign fill_sum = acc_cnt + SUM_W'(pending);
  assign lane_idx = acc_cnt[IDX_W-1:0];

  // A read is only issued when the lane it will land in is guaranteed free:
  // either room remains after the in-flight word, or the full beat leaves now.
  assign fifo_read_en_o = ~reset_i & ~flush_pend &
                          ((fill_sum < FULL) | (full & out_free));

  assign busy_o = (acc_cnt != '0) | pending | m_valid_o | flush_pend;

  // Read-latency tracking, lane accumulation and output beat register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending   <= 1'b0;
      acc       <= '0;
      acc_cnt   <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_count_o <= '0;
    end else begin
      pending <= fire;
      if (xfer) begin
        m_data_o  <= mask_lanes(acc, acc_cnt);
        m_count_o <= acc_cnt[CNT_WIDTH-1:0];
        m_valid_o <= 1'b1;
        if (pending) begin
          acc[0]  <= fifo_data_i;
          acc_cnt <= SUM_W'(1);
        end else begin
          acc_cnt <= '0;
        end
      end else begin
        if (m_valid_o && m_ready_i) begin
          m_valid_o <= 1'b0;
        end
        if (pending) begin
          acc[lane_idx] <= fifo_data_i;
          acc_cnt       <= acc_cnt + SUM_W'(1);
        end
      end
    end
  end

  // Flush request latch: holds off reads until the partial beat leaves, or
  // drops straight away when there turned out to be nothing to emit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flush_pend <= 1'b0;
    end else if (flush_pend) begin
      if ((flush_go && xfer) || (!pending && (acc_cnt == '0))) begin
        flush_pend <= 1'b0;
      end
    end else if (flush_i) begin
      flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Testbench for fifo_read_packer: directed scenarios followed by a randomized
// stream checked against a word-grouping reference model.
module tb_fifo_read_packer;

  localparam int DW = 16;
  localparam int PR = 4;
  localparam int CW = $clog2(PR + 1);
  localparam int BW = DW * PR;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_data_i = '0;
  logic          fifo_read_en_o;
  logic          flush_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [BW-1:0] m_data_o;
  logic [CW-1:0] m_count_o;
  logic          busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int fires = 0;

  logic [DW-1:0] fq[$];
  logic [BW-1:0] out_data[$];
  int            out_cnt[$];
  logic [DW-1:0] sent[$];

  fifo_read_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_read_en_o(fifo_read_en_o),
    .flush_i       (flush_i),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .m_count_o     (m_count_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model with one-cycle registered read data, plus beat capture.
  always @(posedge clk_i) begin
    if (fifo_read_en_o && !fifo_empty_i && fq.size() != 0) begin
      fires       <= fires + 1;
      fifo_data_i <= fq.pop_front();
    end
    if (!reset_i && m_valid_o && m_ready_i) begin
      out_data.push_back(m_data_o);
      out_cnt.push_back(int'(m_count_o));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
    fifo_empty_i = (fq.size() == 0);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (out_data.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_beats"}, 64'(out_data.size()), 64'(n));
  endtask

  task automatic expect_beat(input string tag, input logic [BW-1:0] exp_d, input int exp_c);
    if (out_data.size() == 0) begin
      chk({tag, "_missing"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_data"}, 64'(out_data.pop_front()), 64'(exp_d));
      chk({tag, "_count"}, 64'(out_cnt.pop_front()), 64'(exp_c));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 64'(fifo_read_en_o), 64'd0);
    chk({tag, "_valid"}, 64'(m_valid_o), 64'd0);
    chk({tag, "_data"},  64'(m_data_o), 64'd0);
    chk({tag, "_count"}, 64'(m_count_o), 64'd0);
    chk({tag, "_busy"},  64'(busy_o), 64'd0);
  endtask

  initial begin
    int            f0;
    int            c;
    logic [BW-1:0] snap;
    logic          stall;
    logic [BW-1:0] e;
    int            nb;

    reset_i      = 1'b1;
    flush_i      = 1'b0;
    m_ready_i    = 1'b1;
    fifo_empty_i = 1'b1;
    tick();
    tick();
    chk_reset_outputs("rst");
    reset_i = 1'b0;
    tick();

    // Two full beats back to back, downstream always ready.
    f0 = fires;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    wait_beats("t1", 2, 40);
    expect_beat("t1_b0", 64'h0004_0003_0002_0001, 4);
    expect_beat("t1_b1", 64'h0008_0007_0006_0005, 4);
    chk("t1_fires", 64'(fires - f0), 64'd8);
    tick();
    chk("t1_idle_busy", 64'(busy_o), 64'd0);

    // Downstream stalls for 6 cycles right after the first beat appears.
    out_data.delete();
    out_cnt.delete();
    f0 = fires;
    for (int i = 9; i <= 16; i++) push(DW'(i));
    c = 0;
    while (!m_valid_o && c < 40) begin
      tick();
      c++;
    end
    chk("t2_first_valid", 64'(m_valid_o), 64'd1);
    m_ready_i = 1'b0;
    snap = m_data_o;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_hold_data", 64'(m_data_o), 64'(snap));
      chk("t2_hold_valid", 64'(m_valid_o), 64'd1);
    end
    chk("t2_fires_in_stall", 64'(fires - f0), 64'd8);
    chk("t2_rd_en_stalled", 64'(fifo_read_en_o), 64'd0);
    m_ready_i = 1'b1;
    wait_beats("t2", 2, 40);
    expect_beat("t2_b0", 64'h000C_000B_000A_0009, 4);
    expect_beat("t2_b1", 64'h0010_000F_000E_000D, 4);

    // Three words then a flush: one partial beat of three lanes.
    out_data.delete();
    out_cnt.delete();
    push(16'h000A);
    push(16'h000B);
    push(16'h000C);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_held_busy", 64'(busy_o), 64'd1);
    chk("t3_no_early_beat", 64'(out_data.size()), 64'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t3_rd_blocked", 64'(fifo_read_en_o), 64'd0);
    wait_beats("t3", 1, 10);
    expect_beat("t3_b0", 64'h0000_000C_000B_000A, 3);
    chk("t3_done_busy", 64'(busy_o), 64'd0);

    // Flush in the same cycle as the read of the second word.
    out_data.delete();
    out_cnt.delete();
    f0 = fires;
    push(16'h0021);
    push(16'h0022);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t4_fires", 64'(fires - f0), 64'd2);
    wait_beats("t4", 1, 10);
    expect_beat("t4_b0", 64'h0000_0000_0022_0021, 2);
    tick();
    chk("t4_done_busy", 64'(busy_o), 64'd0);

    // Flush with nothing held: no beat, pending flush drops, reads resume.
    out_data.delete();
    out_cnt.delete();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t5_pend_busy", 64'(busy_o), 64'd1);
    chk("t5_pend_rd_en", 64'(fifo_read_en_o), 64'd0);
    tick();
    chk("t5_clear_busy", 64'(busy_o), 64'd0);
    chk("t5_resume_rd_en", 64'(fifo_read_en_o), 64'd1);
    chk("t5_no_beat", 64'(out_data.size()), 64'd0);

    // Reset with two words held and one in flight.
    push(16'h0031);
    push(16'h0032);
    push(16'h0033);
    tick();
    tick();
    tick();
    chk("t6_busy_before", 64'(busy_o), 64'd1);
    reset_i = 1'b1;
    tick();
    chk_reset_outputs("t6_rst");
    reset_i = 1'b0;
    for (int i = 1; i <= 4; i++) push(DW'(16'h0060 + i));
    wait_beats("t6", 1, 20);
    expect_beat("t6_b0", 64'h0064_0063_0062_0061, 4);
    tick();

    // Randomized stream: beats must be the pushed words grouped in order.
    out_data.delete();
    out_cnt.delete();
    sent.delete();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 60) begin
        e[DW-1:0] = DW'($urandom);
        sent.push_back(e[DW-1:0]);
        push(e[DW-1:0]);
      end
      m_ready_i = ($urandom_range(0, 99) < 70);
      stall = m_valid_o && !m_ready_i;
      snap  = m_data_o;
      tick();
      if (stall) chk("rnd_stall_stable", 64'(m_data_o), 64'(snap));
    end
    while ((sent.size() % PR) != 0) begin
      e[DW-1:0] = DW'($urandom);
      sent.push_back(e[DW-1:0]);
      push(e[DW-1:0]);
    end
    m_ready_i = 1'b1;
    nb = sent.size() / PR;
    wait_beats("rnd", nb, 400);
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int k = 0; k < PR; k++) e[k*DW +: DW] = sent[b*PR + k];
      expect_beat("rnd_beat", e, PR);
    end
    tick();
    chk("rnd_idle_busy", 64'(busy_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
